ps2tx: RTL and testbench

PS2TX -- requirements
Module: ps2tx

---
 rtl/ps2tx.sv | 227 ++++++++++++++++++++++
 tb/tb_ps2tx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2tx.sv
`timescale 1ns/1ps
// ps2tx: host-to-device PS/2 transmitter.
// Sends one command byte to a PS/2 device. The host pulls the clock low
// (inhibit), then presents the start bit and releases the clock. The device
// then generates the clock, and the host shifts out the data bits, odd
// parity and the stop bit. It then samples the device ACK and waits for the
// bus to go idle.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   ps2_clk      PS/2 clock line read back from the pad
//   ps2_data     PS/2 data line read back from the pad
//   samplen      sampling tick; edge detect and tick counters advance on it
//   wren, d      write strobe and command byte
//   ps2_clk_oe   1 = pull clock low (open drain)
//   ps2_data_oe  1 = pull data low (open drain)
//   busy         transfer in progress
//   done         one-clk pulse at the end of every transfer
//   err          no ACK or timeout; valid with done, held until next wren
//   dbg_state    current FSM state
//
// Handshake: wren is accepted on any clk where busy=0. The byte on d is
// captured in that same cycle, and busy rises on the next clk. A wren while
// busy=1 is dropped without effect. Every accepted wren is answered by
// exactly one done pulse, unless reset aborts the transfer.
module ps2tx #(
  parameter int INHIBIT_TICKS = 8,
  parameter int TIMEOUT_TICKS = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       samplen,
  input  logic       wren,
  input  logic [7:0] d,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] dbg_state
);

  localparam int TW = 16;
  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_TICKS - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_ACK, S_RELEASE
  } state_t;

  logic [7:0]    r_filt_sh;
  logic          r_filt;
  logic [1:0]    r_hist;
  logic          w_fall;

  state_t        r_state, w_state_n;
  logic [TW-1:0] r_tick, w_tick_n, w_tick_sat;
  logic [3:0]    r_bitcnt, w_bitcnt_n;
  logic [8:0]    r_frame, w_frame_n;
  logic          r_clk_oe, w_clk_oe_n;
  logic          r_data_oe, w_data_oe_n;
  logic          r_busy, w_busy_n;
  logic          r_done, w_done_n;
  logic          r_err, w_err_n;
  logic          w_timeout;

  // Glitch filter: the level changes only after 8 identical clk samples.
  // r_hist[1] is the previous filtered level, r_hist[0] the current one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt_sh <= '1;
      r_filt    <= 1'b1;
      r_hist    <= 2'b11;
    end else begin
      r_filt_sh <= {r_filt_sh[6:0], ps2_clk};
      if (&r_filt_sh)
        r_filt <= 1'b1;
      else if (~|r_filt_sh)
        r_filt <= 1'b0;
      if (samplen)
        r_hist <= {r_hist[0], r_filt};
    end
  end

  // samplen is a single-clk strobe, so the event is one clk wide.
  assign w_fall     = samplen & r_hist[1] & ~r_hist[0];
  assign w_tick_sat = (r_tick == '1) ? r_tick : r_tick + TW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_tick    <= '0;
      r_bitcnt  <= '0;
      r_frame   <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_tick    <= w_tick_n;
      r_bitcnt  <= w_bitcnt_n;
      r_frame   <= w_frame_n;
      r_clk_oe  <= w_clk_oe_n;
      r_data_oe <= w_data_oe_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_err     <= w_err_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_tick_n    = r_tick;
    w_bitcnt_n  = r_bitcnt;
    w_frame_n   = r_frame;
    w_clk_oe_n  = r_clk_oe;
    w_data_oe_n = r_data_oe;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;
    w_err_n     = r_err;
    w_timeout   = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_clk_oe_n  = 1'b0;
        w_data_oe_n = 1'b0;
        if (wren) begin
          // r_frame holds {parity, byte} and is shifted out LSB first.
          w_frame_n  = {~^d, d};
          w_err_n    = 1'b0;
          w_busy_n   = 1'b1;
          w_clk_oe_n = 1'b1;
          w_tick_n   = '0;
          w_state_n  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (samplen) begin
          if (r_tick >= INH_LAST) begin
            w_data_oe_n = 1'b1;
            w_tick_n    = '0;
            w_state_n   = S_START;
          end else begin
            w_tick_n = w_tick_sat;
          end
        end
      end
      S_START: begin
        // Releasing the clock while data stays low presents the start bit.
        if (samplen) begin
          w_clk_oe_n = 1'b0;
          w_tick_n   = '0;
          w_bitcnt_n = '0;
          w_state_n  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_fall) begin
          w_tick_n = '0;
          if (r_bitcnt == 4'd9) begin
            w_data_oe_n = 1'b0;  // stop bit: release data
            w_state_n   = S_ACK;
          end else begin
            w_data_oe_n = ~r_frame[0];
            w_frame_n   = {1'b1, r_frame[8:1]};
            w_bitcnt_n  = r_bitcnt + 4'd1;
          end
        end else if (samplen) begin
          if (r_tick >= TO_LAST) w_timeout = 1'b1;
          else                   w_tick_n  = w_tick_sat;
        end
      end
      S_ACK: begin
        if (w_fall) begin
          w_err_n   = ps2_data;  // device pulls data low to acknowledge
          w_tick_n  = '0;
          w_state_n = S_RELEASE;
        end else if (samplen) begin
          if (r_tick >= TO_LAST) w_timeout = 1'b1;
          else                   w_tick_n  = w_tick_sat;
        end
      end
      S_RELEASE: begin
        if (samplen) begin
          if (r_filt && ps2_data) begin
            w_done_n  = 1'b1;
            w_busy_n  = 1'b0;
            w_state_n = S_IDLE;
          end else if (r_tick >= TO_LAST) begin
            w_timeout = 1'b1;
          end else begin
            w_tick_n = w_tick_sat;
          end
        end
      end
      default: begin
        w_state_n   = S_IDLE;
        w_clk_oe_n  = 1'b0;
        w_data_oe_n = 1'b0;
        w_busy_n    = 1'b0;
      end
    endcase

    if (w_timeout) begin
      w_err_n     = 1'b1;
      w_clk_oe_n  = 1'b0;
      w_data_oe_n = 1'b0;
      w_done_n    = 1'b1;
      w_busy_n    = 1'b0;
      w_tick_n    = '0;
      w_state_n   = S_IDLE;
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ps2tx.sv
`timescale 1ns/1ps
module tb_ps2tx;

  localparam int INH  = 8;
  localparam int TO   = 200;
  localparam int HALF = 40;  // device clock half period, in clk cycles
  localparam int SDIV = 4;   // one samplen strobe every SDIV clks

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       samplen = 1'b0;
  logic       wren = 1'b0;
  logic [7:0] d = 8'h00;
  logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic [2:0] dbg_state;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  // Open-drain bus: either side may pull a line low.
  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2tx #(.INHIBIT_TICKS(INH), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk_line), .ps2_data(ps2_data_line),
    .samplen(samplen), .wren(wren), .d(d),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  int tick_total = 0;
  initial begin
    int sdiv;
    sdiv = 0;
    forever begin
      @(negedge clk);
      sdiv = (sdiv + 1) % SDIV;
      samplen = (sdiv == 0);
      if (samplen) tick_total++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- done monitor ----------------
  int   done_cnt = 0;
  int   dbl_done = 0;
  logic prev_done = 1'b0;
  logic err_at_done = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      err_at_done = err;
      if (prev_done) dbl_done++;
    end
    prev_done = done;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass = 0;
  logic [10:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference frame in wire order: start, d[0..7], odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    ones = $countones(b);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
    f[9]  = ((ones % 2) == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  // ---------------- device model ----------------
  // Waits for the host start condition, then clocks n_edges falling edges,
  // sampling data at the end of each high phase.
  task automatic device(input bit ack, input int glitch_at, input int n_edges,
                        output logic [10:0] got, output bit started);
    got = '0;
    started = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) begin
        started = 1'b1;
        break;
      end
    end
    if (!started) return;
    repeat (HALF) @(negedge clk);
    for (int e = 0; e < n_edges; e++) begin
      repeat (HALF/2) @(negedge clk);
      if (e == glitch_at) begin
        dev_clk_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b0;
      end
      repeat (HALF/2) @(negedge clk);
      got[e] = ps2_data_line;
      if (e == 10 && ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_busy_drop"}, ok, 1'b1);
  endtask

  // ---------------- full transfer ----------------
  task automatic run_vec(input logic [7:0] b, input bit ack, input int glitch_at,
                         input bit intrude, input logic exp_err, input string tag);
    logic [10:0] got, expf;
    bit started, seen;
    int dc0, t0, dt;
    exp_q.push_back(model_frame(b));
    dc0 = done_cnt;
    d = b;
    wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
    check({tag, "_busy_set"}, busy, 1'b1);
    check({tag, "_inhibit_oe"}, {ps2_clk_oe, ps2_data_oe}, 2'b10);
    t0 = tick_total;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (ps2_data_oe) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    dt = tick_total - t0;
    check({tag, "_inhibit_ticks_ok"}, seen && dt >= INH - 1 && dt <= INH + 1, 1'b1);
    check({tag, "_start_both_low"}, {ps2_clk_oe, ps2_data_oe}, 2'b11);
    fork
      device(ack, glitch_at, 11, got, started);
      begin
        if (intrude) begin
          repeat (5) @(negedge clk);
          d = 8'h00;
          wren = 1'b1;
          @(negedge clk);
          wren = 1'b0;
        end
      end
    join
    check({tag, "_started"}, started, 1'b1);
    expf = exp_q.pop_front();
    check({tag, "_frame"}, got, expf);
    wait_idle(tag);
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, done_cnt - dc0, 1);
    check({tag, "_err_at_done"}, err_at_done, exp_err);
    check({tag, "_err_held"}, err, exp_err);
    check({tag, "_idle_oe"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
  endtask

  typedef struct {
    logic [7:0] d;
    bit         ack;
    int         glitch_at;
    bit         intrude;
    logic       exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [10:0] got;
    bit started, seen;
    int dc0, t0, dt;

    // Directed entries, then randomized ones; expected err follows the ACK rule.
    tbl[0] = '{8'hED, 1'b1, -1, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 1'b0, -1, 1'b0, 1'b1};
    tbl[2] = '{8'h5A, 1'b1,  4, 1'b0, 1'b0};
    tbl[3] = '{8'h81, 1'b1, -1, 1'b1, 1'b0};
    for (int i = 4; i < 8; i++) begin
      tbl[i].d         = 8'($urandom_range(0, 255));
      tbl[i].ack       = ($urandom_range(0, 3) != 0);
      tbl[i].glitch_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 9)) : -1;
      tbl[i].intrude   = 1'b0;
      tbl[i].exp_err   = !tbl[i].ack;
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 8; i++)
      run_vec(tbl[i].d, tbl[i].ack, tbl[i].glitch_at, tbl[i].intrude,
              tbl[i].exp_err, $sformatf("vec%0d", i));

    // Device never clocks: timeout after TO ticks from start-bit release.
    dc0 = done_cnt;
    d = 8'h3C;
    wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!ps2_clk_oe && ps2_data_oe) begin
        seen = 1'b1;
        break;
      end
    end
    check("to_shift_entered", seen, 1'b1);
    t0 = tick_total;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    dt = tick_total - t0;
    check("to_done_seen", seen, 1'b1);
    check("to_ticks_ok", dt >= TO - 1 && dt <= TO + 1, 1'b1);
    check("to_err", err, 1'b1);
    check("to_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    repeat (3) @(negedge clk);
    check("to_done_count", done_cnt - dc0, 1);
    check("to_busy", busy, 1'b0);

    // Reset after the 5th falling edge: d[4]=0 so data is being pulled low.
    dc0 = done_cnt;
    d = 8'hA5;
    wren = 1'b1;
    @(negedge clk);
    wren = 1'b0;
    device(1'b1, -1, 5, got, started);
    check("rstmid_started", started, 1'b1);
    check("rstmid_partial_frame", got[4:0], model_frame(8'hA5) & 11'h01F);
    check("rstmid_pre_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    reset = 1'b0;
    #1;
    check("rstmid_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("rstmid_busy", busy, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (50) @(negedge clk);
    check("rstmid_no_done", done_cnt - dc0, 0);

    // Recovery after the abort.
    run_vec(8'hED, 1'b1, -1, 1'b0, 1'b0, "post_rst");

    check("done_single_cycle", dbl_done, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
